fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage. Holds the fetch PC and the F/D
//                pipeline latch, handles stall (freeze), taken branch/jump
//                (redirect plus bubble injection), and counts fetched
//                instructions and flush bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branched_jumped,
    input  logic [31:0] target_pc,
    input  logic [31:0] q_imem,
    output logic [11:0] address_imem,
    output logic [31:0] pc_out,
    output logic [31:0] insn_fd_out,
    output logic [31:0] pc_fd_out,
    output logic        fd_valid,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count,
    output logic [1:0]  state
);

    localparam logic [31:0] BUBBLE = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        HOLD  = 2'b10,
        FLUSH = 2'b11
    } state_t;

    state_t cur_state;
    state_t next_state;

    // Per-edge action, decoded once so the FSM and datapath always agree.
    logic do_redirect;
    logic do_advance;

    // Action decode: redirect beats stall beats advance; BOOT does nothing.
    always_comb begin
        do_redirect = 1'b0;
        do_advance  = 1'b0;
        next_state  = cur_state;
        if (cur_state == BOOT) begin
            next_state = RUN;
        end else if (branched_jumped) begin
            do_redirect = 1'b1;
            next_state  = FLUSH;
        end else if (stall) begin
            next_state  = HOLD;
        end else begin
            do_advance  = 1'b1;
            next_state  = RUN;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state <= BOOT;
        end else begin
            cur_state <= next_state;
        end
    end

    // PC, F/D latch and counters; a stall simply leaves everything untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_out       <= 32'h0;
            insn_fd_out  <= BUBBLE;
            pc_fd_out    <= 32'h0;
            fd_valid     <= 1'b0;
            fetch_count  <= 32'h0;
            bubble_count <= 32'h0;
        end else if (do_redirect) begin
            pc_out       <= target_pc;
            insn_fd_out  <= BUBBLE;
            pc_fd_out    <= 32'h0;
            fd_valid     <= 1'b0;
            bubble_count <= bubble_count + 32'h1;
        end else if (do_advance) begin
            pc_out       <= pc_out + 32'h1;
            insn_fd_out  <= q_imem;
            pc_fd_out    <= pc_out + 32'h1;
            fd_valid     <= 1'b1;
            fetch_count  <= fetch_count + 32'h1;
        end
    end

    assign address_imem = pc_out[11:0];
    assign state        = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage using a table of
//                per-edge vectors plus a hand-written async-reset sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branched_jumped;
    logic [31:0] target_pc;
    logic [31:0] q_imem;
    logic [11:0] address_imem;
    logic [31:0] pc_out;
    logic [31:0] insn_fd_out;
    logic [31:0] pc_fd_out;
    logic        fd_valid;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
    logic [1:0]  state;

    int passed = 0;
    int total  = 0;

    fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .branched_jumped (branched_jumped),
        .target_pc       (target_pc),
        .q_imem          (q_imem),
        .address_imem    (address_imem),
        .pc_out          (pc_out),
        .insn_fd_out     (insn_fd_out),
        .pc_fd_out       (pc_fd_out),
        .fd_valid        (fd_valid),
        .fetch_count     (fetch_count),
        .bubble_count    (bubble_count),
        .state           (state)
    );

    always #5 clock = ~clock;

    // Instruction memory model: address-dependent word, same-cycle read.
    function automatic logic [31:0] word_at(input logic [11:0] a);
        return {20'hC0DE0, a};
    endfunction

    always_comb q_imem = word_at(address_imem);

    typedef struct {
        logic        st;
        logic        bj;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_insn;
        logic [31:0] e_pcfd;
        logic        e_valid;
        logic [1:0]  e_state;
        logic [31:0] e_fc;
        logic [31:0] e_bc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add(input logic st, input logic bj, input logic [31:0] tgt,
                       input logic [31:0] pc, input logic [31:0] insn, input logic [31:0] pcfd,
                       input logic v, input logic [1:0] s, input logic [31:0] fc, input logic [31:0] bc);
        vec_t r;
        r.st = st; r.bj = bj; r.tgt = tgt; r.e_pc = pc; r.e_insn = insn; r.e_pcfd = pcfd;
        r.e_valid = v; r.e_state = s; r.e_fc = fc; r.e_bc = bc;
        vecs.push_back(r);
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] insn,
                             input logic [31:0] pcfd, input logic v, input logic [1:0] s,
                             input logic [31:0] fc, input logic [31:0] bc);
        chk({tag, " pc_out"},       pc_out,                pc);
        chk({tag, " address_imem"}, {20'h0, address_imem}, {20'h0, pc[11:0]});
        chk({tag, " insn_fd_out"},  insn_fd_out,           insn);
        chk({tag, " pc_fd_out"},    pc_fd_out,             pcfd);
        chk({tag, " fd_valid"},     {31'h0, fd_valid},     {31'h0, v});
        chk({tag, " state"},        {30'h0, state},        {30'h0, s});
        chk({tag, " fetch_count"},  fetch_count,           fc);
        chk({tag, " bubble_count"}, bubble_count,          bc);
    endtask

    localparam logic [1:0] S_BOOT = 2'b00, S_RUN = 2'b01, S_HOLD = 2'b10, S_FLUSH = 2'b11;

    initial begin
        reset = 1'b1; stall = 1'b0; branched_jumped = 1'b0; target_pc = 32'h0;

        // st bj tgt          pc           insn                pcfd         v  state    fc  bc
        add(1, 1, 32'h99,     32'h0,       32'h0,              32'h0,       0, S_RUN,   0,  0); // BOOT ignores inputs
        add(0, 0, 32'h0,      32'h1,       word_at(12'h000),   32'h1,       1, S_RUN,   1,  0);
        add(0, 0, 32'h0,      32'h2,       word_at(12'h001),   32'h2,       1, S_RUN,   2,  0);
        add(0, 0, 32'h0,      32'h3,       word_at(12'h002),   32'h3,       1, S_RUN,   3,  0);
        add(0, 0, 32'h0,      32'h4,       word_at(12'h003),   32'h4,       1, S_RUN,   4,  0);
        add(0, 0, 32'h0,      32'h5,       word_at(12'h004),   32'h5,       1, S_RUN,   5,  0);
        add(1, 0, 32'h0,      32'h5,       word_at(12'h004),   32'h5,       1, S_HOLD,  5,  0);
        add(1, 0, 32'h0,      32'h5,       word_at(12'h004),   32'h5,       1, S_HOLD,  5,  0);
        add(1, 0, 32'h0,      32'h5,       word_at(12'h004),   32'h5,       1, S_HOLD,  5,  0);
        add(0, 0, 32'h0,      32'h6,       word_at(12'h005),   32'h6,       1, S_RUN,   6,  0);
        add(0, 0, 32'h0,      32'h7,       word_at(12'h006),   32'h7,       1, S_RUN,   7,  0);
        add(0, 0, 32'h0,      32'h8,       word_at(12'h007),   32'h8,       1, S_RUN,   8,  0);
        add(1, 1, 32'h40,     32'h40,      32'h0,              32'h0,       0, S_FLUSH, 8,  1); // branch beats stall
        add(0, 0, 32'h0,      32'h41,      word_at(12'h040),   32'h41,      1, S_RUN,   9,  1);
        add(0, 1, 32'h10,     32'h10,      32'h0,              32'h0,       0, S_FLUSH, 9,  2);
        add(0, 1, 32'h20,     32'h20,      32'h0,              32'h0,       0, S_FLUSH, 9,  3); // last target wins
        add(0, 0, 32'h0,      32'h21,      word_at(12'h020),   32'h21,      1, S_RUN,   10, 3);
        add(0, 1, 32'hFFF,    32'hFFF,     32'h0,              32'h0,       0, S_FLUSH, 10, 4);
        add(0, 0, 32'h0,      32'h1000,    word_at(12'hFFF),   32'h1000,    1, S_RUN,   11, 4); // address wraps
        add(0, 0, 32'h0,      32'h1001,    word_at(12'h000),   32'h1001,    1, S_RUN,   12, 4);
        add(1, 0, 32'h0,      32'h1001,    word_at(12'h000),   32'h1001,    1, S_HOLD,  12, 4);

        #2;
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, S_BOOT, 32'h0, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            stall           = vecs[i].st;
            branched_jumped = vecs[i].bj;
            target_pc       = vecs[i].tgt;
            @(posedge clock); #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_insn, vecs[i].e_pcfd,
                      vecs[i].e_valid, vecs[i].e_state, vecs[i].e_fc, vecs[i].e_bc);
        end

        // Asynchronous reset in the middle of a HOLD, between clock edges.
        #2;
        reset = 1'b1;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, S_BOOT, 32'h0, 32'h0);
        @(posedge clock); #1;
        chk("rst_held state", {30'h0, state}, {30'h0, S_BOOT});
        @(negedge clock);
        reset = 1'b0; stall = 1'b0;
        @(posedge clock); #1;
        check_all("post_rst boot", 32'h0, 32'h0, 32'h0, 1'b0, S_RUN, 32'h0, 32'h0);
        @(posedge clock); #1;
        check_all("post_rst adv", 32'h1, word_at(12'h000), 32'h1, 1'b1, S_RUN, 32'h1, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
